// File: rtl/booth_final_cpa.sv
// booth_final_cpa: final carry-propagate adder of the 16-bit radix-4 Booth
// multiplier. Resolves the sum/carry vectors from the Wallace tree into the
// product: product = final_part_0 + (final_part_1 << 1), with carry_out taken
// as bit WIDTH of the (WIDTH+1)-bit sum.
//
// Build option BOOTH_CPA_SPLIT_PIPE_EN:
//   defined   - two-stage pipeline, addition split at LO_W (latency 2, capacity 2)
//   undefined - single registered WIDTH+1 add (latency 1, capacity 1), LO_W unused
module booth_final_cpa #(
    parameter int WIDTH = 32,
    parameter int LO_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] final_part_0,
    input  logic [WIDTH-1:0] final_part_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             carry_out
);

    // The carry vector carries weight 2, so it is shifted once before adding.
    logic [WIDTH:0] p1_shifted;
    logic           in_fire;

    assign p1_shifted = {final_part_1, 1'b0};
    assign in_fire    = in_valid && in_ready;

`ifdef BOOTH_CPA_SPLIT_PIPE_EN

    localparam int HI_W = WIDTH - LO_W;

    logic            s1_valid;
    logic [LO_W-1:0] s1_lo;
    logic            s1_c_lo;
    logic [HI_W-1:0] s1_p0_hi;
    logic [HI_W:0]   s1_p1_hi;

    logic [LO_W:0]   lo_sum;
    logic [HI_W:0]   hi_sum;
    logic            s2_accept;
    logic            s1_advance;

    // Low half resolves in stage 1; the high half of the shifted carry vector
    // is one bit wider than the sum slice because of the shift.
    assign lo_sum     = {1'b0, final_part_0[LO_W-1:0]} + {1'b0, p1_shifted[LO_W-1:0]};
    assign hi_sum     = {1'b0, s1_p0_hi} + s1_p1_hi + {{HI_W{1'b0}}, s1_c_lo};

    assign s2_accept  = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_accept;
    assign in_ready   = !s1_valid || s2_accept;

    // Stage 1: capture the low-half sum with its carry and the raw high slices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c_lo  <= 1'b0;
            s1_p0_hi <= '0;
            s1_p1_hi <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_lo    <= lo_sum[LO_W-1:0];
            s1_c_lo  <= lo_sum[LO_W];
            s1_p0_hi <= final_part_0[WIDTH-1:LO_W];
            s1_p1_hi <= p1_shifted[WIDTH:LO_W];
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: finish the high-half add and present the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
            carry_out <= 1'b0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            product   <= {hi_sum[HI_W-1:0], s1_lo};
            carry_out <= hi_sum[HI_W];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`else

    logic [WIDTH:0] full_sum;
    logic           unused_lo_w;

    // The split point has no meaning for a single-cycle add.
    assign unused_lo_w = |LO_W;
    assign full_sum    = {1'b0, final_part_0} + p1_shifted;
    assign in_ready    = !out_valid || out_ready;

    // Single stage: register the whole WIDTH+1 add straight into the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
            carry_out <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            product   <= full_sum[WIDTH-1:0];
            carry_out <= full_sum[WIDTH];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_booth_final_cpa.sv
// tb_booth_final_cpa: scoreboard bench for booth_final_cpa. The driver pushes
// the hand-computed {carry_out, product} of each accepted pair into a queue;
// a monitor pops and compares on every output transfer.
module tb_booth_final_cpa;

`ifdef BOOTH_CPA_SPLIT_PIPE_EN
    localparam int LAT = 2;
    localparam int CAP = 2;
`else
    localparam int LAT = 1;
    localparam int CAP = 1;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] final_part_0;
    logic [31:0] final_part_1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        carry_out;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_out    = 0;
    logic [32:0] sb[$];

    booth_final_cpa #(.WIDTH(32), .LO_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .final_part_0 (final_part_0),
        .final_part_1 (final_part_1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .carry_out    (carry_out)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Presents one pair and waits for acceptance; returns the number of
    // cycles in_ready was low before the transfer.
    task automatic applyStimulus(input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [31:0] exp_p, input logic exp_c,
                                 output int waits);
        bit done;
        waits        = 0;
        done         = 0;
        in_valid     = 1'b1;
        final_part_0 = p0;
        final_part_1 = p1;
        while (!done && waits < 60) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({exp_c, exp_p});
                n_in++;
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got no in_ready expected in_ready within 60 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_empty", 33'(sb.size()), 33'd0);
    endtask

    // Monitor: compare every output transfer against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got %h expected no output", {carry_out, product});
            end else begin
                checkOutput("result", {carry_out, product}, sb.pop_front());
            end
        end
    end

    // Stream table: {p0, p1, expected product, expected carry}.
    logic [31:0] st_p0 [8] = '{32'h00000001, 32'h12345678, 32'h00000000, 32'h80000000,
                               32'h0000FFFF, 32'h11111111, 32'hFFFF0000, 32'hAAAAAAAA};
    logic [31:0] st_p1 [8] = '{32'h00000001, 32'h00000000, 32'h40000000, 32'h40000000,
                               32'h00008000, 32'h11111111, 32'h00010000, 32'h2AAAAAAA};
    logic [31:0] st_ep [8] = '{32'h00000003, 32'h12345678, 32'h80000000, 32'h00000000,
                               32'h0001FFFF, 32'h33333333, 32'h00010000, 32'hFFFFFFFE};
    logic        st_ec [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Backpressure table A, B, C.
    logic [31:0] bp_p0 [3] = '{32'h00000010, 32'h00000100, 32'h00001000};
    logic [31:0] bp_p1 [3] = '{32'h00000001, 32'h00000002, 32'h00000003};
    logic [31:0] bp_ep [3] = '{32'h00000012, 32'h00000104, 32'h00001006};

    // Main sequence of directed tests.
    initial begin
        int w;
        int lat;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        final_part_0 = '0;
        final_part_1 = '0;
        #1;
        checkOutput("reset_out_valid", 33'(out_valid), 33'd0);
        checkOutput("reset_product",   33'(product),   33'd0);
        checkOutput("reset_carry",     33'(carry_out), 33'd0);
        checkOutput("reset_in_ready",  33'(in_ready),  33'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Carry across the split and latency.
        applyStimulus(32'h0000FFFF, 32'h00000001, 32'h00010001, 1'b0, w);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("latency", 33'(lat), 33'(LAT));
        drain();

        // Carry out of the top bit.
        applyStimulus(32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b1, w);
        drain();

        // Back-to-back streaming with in_ready held high.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(st_p0[i], st_p1[i], st_ep[i], st_ec[i], w);
            checkOutput("stream_in_ready_waits", 33'(w), 33'd0);
        end
        drain();

        // Backpressure: fill to capacity, check stall behaviour, then release.
        out_ready = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            applyStimulus(bp_p0[i], bp_p1[i], bp_ep[i], 1'b0, w);
            checkOutput("bp_fill_waits", 33'(w), 33'd0);
        end
        fork
            begin
                for (int i = CAP; i < 3; i++)
                    applyStimulus(bp_p0[i], bp_p1[i], bp_ep[i], 1'b0, w);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready_low", 33'(in_ready),  33'd0);
                    checkOutput("bp_out_valid",    33'(out_valid), 33'd1);
                    checkOutput("bp_hold_product", 33'(product),   33'(bp_ep[0]));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while a result is in flight.
        out_ready = 1'b0;
        applyStimulus(32'h00000005, 32'h00000003, 32'h0000000B, 1'b0, w);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", 33'(out_valid), 33'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 33'(out_valid), 33'd0);
        checkOutput("midreset_product",   33'(product),   33'd0);
        checkOutput("midreset_carry",     33'(carry_out), 33'd0);
        sb.delete();
        n_in--;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("post_reset_no_stale", 33'(out_valid), 33'd0);
            checkOutput("post_reset_in_ready", 33'(in_ready),  33'd1);
        end
        @(posedge clk);
        #1;

        // Zero operands, then idle.
        applyStimulus(32'h00000000, 32'h00000000, 32'h00000000, 1'b0, w);
        drain();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("idle_out_valid", 33'(out_valid), 33'd0);
        end

        checkOutput("outputs_delivered", 33'(n_out), 33'(n_in));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got still running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
